vx_warp_sched: RTL and testbench



---
 rtl/vx_sched_pkg.sv | 22 ++
 rtl/vx_rr_picker.sv | 30 +++
 rtl/vx_warp_sched.sv | 124 ++++++++++++
 tb/tb_vx_warp_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vx_sched_pkg.sv
// rtl/vx_sched_pkg.sv - shared types and constants for the warp scheduler
package vx_sched_pkg;

    localparam int unsigned PC_INC = 4;

    localparam int SCHED_UUID_W  = 16;
    localparam int SCHED_NW_W    = 2;
    localparam int SCHED_TMASK_W = 4;
    localparam int SCHED_XLEN    = 32;

    function automatic int nw_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [SCHED_UUID_W-1:0]  uuid;
        logic [SCHED_NW_W-1:0]    wid;
        logic [SCHED_TMASK_W-1:0] tmask;
        logic [SCHED_XLEN-1:0]    pc;
    } sched_req_t;

endpackage

// File: rtl/vx_rr_picker.sv
// rtl/vx_rr_picker.sv - combinational round-robin picker, search starts at ptr + 1
module vx_rr_picker
    import vx_sched_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    localparam int NW_WIDTH = nw_width(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] req,
    input  logic [NW_WIDTH-1:0]  ptr,
    output logic                 gnt_valid,
    output logic [NW_WIDTH-1:0]  gnt_idx
);

    logic [NW_WIDTH-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            idx = ptr + NW_WIDTH'(i);
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/vx_warp_sched.sv
// rtl/vx_warp_sched.sv - round-robin warp scheduler feeding the fetch stage
module vx_warp_sched
    import vx_sched_pkg::*;
#(
    parameter int          NUM_WARPS  = 4,
    parameter int          THREAD_CNT = 4,
    parameter int          XLEN       = 32,
    parameter int          UUID_WIDTH = 16,
    parameter logic [31:0] STARTUP_PC = 32'h8000_0000,
    localparam int         NW_WIDTH   = nw_width(NUM_WARPS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spawn_valid,
    input  logic [NW_WIDTH-1:0]   spawn_wid,
    input  logic [XLEN-1:0]       spawn_pc,
    input  logic [THREAD_CNT-1:0] spawn_tmask,
    input  logic                  branch_valid,
    input  logic [NW_WIDTH-1:0]   branch_wid,
    input  logic [XLEN-1:0]       branch_pc,
    input  logic [THREAD_CNT-1:0] branch_tmask,
    input  logic                  unlock_valid,
    input  logic [NW_WIDTH-1:0]   unlock_wid,
    output logic                  sched_valid,
    output logic [UUID_WIDTH-1:0] sched_uuid,
    output logic [NW_WIDTH-1:0]   sched_wid,
    output logic [THREAD_CNT-1:0] sched_tmask,
    output logic [XLEN-1:0]       sched_pc,
    input  logic                  sched_ready,
    output logic                  busy
);

    logic [NUM_WARPS-1:0]  active_r, active_n;
    logic [NUM_WARPS-1:0]  stalled_r, stalled_n;
    logic [XLEN-1:0]       pc_r    [NUM_WARPS];
    logic [XLEN-1:0]       pc_n    [NUM_WARPS];
    logic [THREAD_CNT-1:0] tmask_r [NUM_WARPS];
    logic [THREAD_CNT-1:0] tmask_n [NUM_WARPS];
    logic [NW_WIDTH-1:0]   last_wid;
    logic [UUID_WIDTH-1:0] uuid_cnt;
    logic                  gnt_valid;
    logic [NW_WIDTH-1:0]   gnt_idx;
    logic                  out_free;
    logic                  load;

    vx_rr_picker #(
        .NUM_WARPS (NUM_WARPS)
    ) u_picker (
        .req       (active_r & ~stalled_r),
        .ptr       (last_wid),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign out_free = ~sched_valid | sched_ready;
    assign load     = out_free & gnt_valid;

    // Branch overrides spawn overrides issue/unlock on the same warp.
    always_comb begin
        active_n  = active_r;
        stalled_n = stalled_r;
        pc_n      = pc_r;
        tmask_n   = tmask_r;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (branch_valid && branch_wid == NW_WIDTH'(w) && active_r[w]) begin
                pc_n[w]      = branch_pc;
                tmask_n[w]   = branch_tmask;
                stalled_n[w] = 1'b0;
                active_n[w]  = |branch_tmask;
            end else if (spawn_valid && spawn_wid == NW_WIDTH'(w) && !active_r[w]) begin
                pc_n[w]      = spawn_pc;
                tmask_n[w]   = spawn_tmask;
                stalled_n[w] = 1'b0;
                active_n[w]  = 1'b1;
            end else if (load && gnt_idx == NW_WIDTH'(w)) begin
                stalled_n[w] = 1'b1;
                pc_n[w]      = pc_r[w] + XLEN'(PC_INC);
            end else if (unlock_valid && unlock_wid == NW_WIDTH'(w)) begin
                stalled_n[w] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_r  <= NUM_WARPS'(1);
            stalled_r <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_r[w]    <= (w == 0) ? XLEN'(STARTUP_PC) : '0;
                tmask_r[w] <= (w == 0) ? THREAD_CNT'(1) : '0;
            end
            busy <= 1'b1;
        end else begin
            active_r  <= active_n;
            stalled_r <= stalled_n;
            pc_r      <= pc_n;
            tmask_r   <= tmask_n;
            busy      <= |active_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sched_valid <= 1'b0;
            sched_uuid  <= '0;
            sched_wid   <= '0;
            sched_tmask <= '0;
            sched_pc    <= '0;
            last_wid    <= NW_WIDTH'(NUM_WARPS - 1);
            uuid_cnt    <= '0;
        end else if (out_free) begin
            sched_valid <= gnt_valid;
            if (gnt_valid) begin
                sched_uuid  <= uuid_cnt;
                sched_wid   <= gnt_idx;
                sched_tmask <= tmask_r[gnt_idx];
                sched_pc    <= pc_r[gnt_idx];
                last_wid    <= gnt_idx;
                uuid_cnt    <= uuid_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vx_warp_sched.sv
// tb/tb_vx_warp_sched.sv - directed self-checking bench for vx_warp_sched
module tb_vx_warp_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spawn_valid;
    logic [1:0]  spawn_wid;
    logic [31:0] spawn_pc;
    logic [3:0]  spawn_tmask;
    logic        branch_valid;
    logic [1:0]  branch_wid;
    logic [31:0] branch_pc;
    logic [3:0]  branch_tmask;
    logic        unlock_valid;
    logic [1:0]  unlock_wid;
    logic        sched_valid;
    logic [15:0] sched_uuid;
    logic [1:0]  sched_wid;
    logic [3:0]  sched_tmask;
    logic [31:0] sched_pc;
    logic        sched_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    vx_warp_sched dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spawn_valid  (spawn_valid),
        .spawn_wid    (spawn_wid),
        .spawn_pc     (spawn_pc),
        .spawn_tmask  (spawn_tmask),
        .branch_valid (branch_valid),
        .branch_wid   (branch_wid),
        .branch_pc    (branch_pc),
        .branch_tmask (branch_tmask),
        .unlock_valid (unlock_valid),
        .unlock_wid   (unlock_wid),
        .sched_valid  (sched_valid),
        .sched_uuid   (sched_uuid),
        .sched_wid    (sched_wid),
        .sched_tmask  (sched_tmask),
        .sched_pc     (sched_pc),
        .sched_ready  (sched_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [1:0] wid, input logic [31:0] pc,
                           input logic [3:0] tm, input logic [15:0] uuid);
        chk({tag, ".valid"}, 64'(sched_valid), 64'(1'b1));
        chk({tag, ".wid"},   64'(sched_wid),   64'(wid));
        chk({tag, ".pc"},    64'(sched_pc),    64'(pc));
        chk({tag, ".tmask"}, 64'(sched_tmask), 64'(tm));
        chk({tag, ".uuid"},  64'(sched_uuid),  64'(uuid));
    endtask

    logic [1:0]  rr_wid  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] rr_pc   [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h8000_0008, 32'h1004};
    logic [3:0]  rr_tm   [5] = '{4'hF, 4'hF, 4'hF, 4'h1, 4'hF};

    initial begin
        reset_n = 1'b0;
        spawn_valid = 0; spawn_wid = 0; spawn_pc = 0; spawn_tmask = 0;
        branch_valid = 0; branch_wid = 0; branch_pc = 0; branch_tmask = 0;
        unlock_valid = 0; unlock_wid = 0;
        sched_ready = 1'b1;
        tick(); tick();
        chk("rst.valid", 64'(sched_valid), 64'(0));
        chk("rst.busy",  64'(busy), 64'(1));
        chk("rst.pc",    64'(sched_pc), 64'(0));
        chk("rst.uuid",  64'(sched_uuid), 64'(0));
        reset_n = 1'b1;

        // first request from warp 0
        tick();
        chk_req("first", 2'd0, 32'h8000_0000, 4'h1, 16'd0);
        tick();
        chk("stalled0.a", 64'(sched_valid), 64'(0));
        tick();
        chk("stalled0.b", 64'(sched_valid), 64'(0));
        unlock_valid = 1; unlock_wid = 2'd0;
        tick();
        unlock_valid = 0;
        chk("release.lat", 64'(sched_valid), 64'(0));
        tick();
        chk_req("second", 2'd0, 32'h8000_0004, 4'h1, 16'd1);

        // hold with ready low for 5 cycles while spawning warps 1..3
        sched_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                spawn_valid = 1; spawn_wid = 2'(c + 1);
                spawn_pc = 32'h1000 * (c + 1); spawn_tmask = 4'hF;
            end else begin
                spawn_valid = 0;
            end
            tick();
            chk_req($sformatf("hold%0d", c), 2'd0, 32'h8000_0004, 4'h1, 16'd1);
        end
        spawn_valid = 0;

        // round robin with each issued warp unlocked the following cycle
        sched_ready = 1'b1;
        unlock_valid = 1; unlock_wid = 2'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_req($sformatf("rr%0d", k), rr_wid[k], rr_pc[k], rr_tm[k], 16'(k + 2));
            unlock_wid = rr_wid[k];
        end
        unlock_valid = 0;
        sched_ready = 1'b0;

        // retire warp 2; then branch beats spawn on warp 1; spawn to active warp 3 ignored
        branch_valid = 1; branch_wid = 2'd2; branch_pc = 32'h2000; branch_tmask = 4'h0;
        tick();
        chk("ret2.busy", 64'(busy), 64'(1));
        branch_wid = 2'd1; branch_pc = 32'h3000; branch_tmask = 4'h3;
        spawn_valid = 1; spawn_wid = 2'd1; spawn_pc = 32'h5555; spawn_tmask = 4'h1;
        tick();
        branch_valid = 0;
        spawn_wid = 2'd3; spawn_pc = 32'h7777; spawn_tmask = 4'h1;
        tick();
        spawn_valid = 0;
        chk_req("held", 2'd1, 32'h1004, 4'hF, 16'd6);
        sched_ready = 1'b1;
        tick();
        chk_req("skip2", 2'd3, 32'h3004, 4'hF, 16'd7);
        tick();
        chk_req("w0", 2'd0, 32'h8000_000C, 4'h1, 16'd8);
        tick();
        chk_req("brwin", 2'd1, 32'h3000, 4'h3, 16'd9);
        tick();
        chk("drain.valid", 64'(sched_valid), 64'(0));

        // retire remaining warps
        branch_valid = 1; branch_tmask = 4'h0; branch_pc = 32'h0;
        branch_wid = 2'd0; tick();
        branch_wid = 2'd1; tick();
        chk("ret1.busy", 64'(busy), 64'(1));
        branch_wid = 2'd3; tick();
        branch_valid = 0;
        chk("retall.busy", 64'(busy), 64'(0));
        tick();
        chk("retall.valid", 64'(sched_valid), 64'(0));

        // reset with a request pending
        sched_ready = 1'b0;
        spawn_valid = 1; spawn_wid = 2'd1; spawn_pc = 32'h100; spawn_tmask = 4'h1;
        tick();
        spawn_valid = 0;
        tick();
        chk_req("pend", 2'd1, 32'h100, 4'h1, 16'd10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.valid", 64'(sched_valid), 64'(0));
        chk("arst.busy",  64'(busy), 64'(1));
        chk("arst.uuid",  64'(sched_uuid), 64'(0));
        tick();
        reset_n = 1'b1;
        sched_ready = 1'b1;
        tick();
        chk_req("post_rst", 2'd0, 32'h8000_0000, 4'h1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
